gin_multicast_sender: RTL
=========================

// Module: gin_multicast_sender
// PURPOSE
//  Source end of the GIN multicast bus. Accepts (row_tag, col_tag, value) packets from the
//  upstream buffer, queues them in a small FIFO and presents them to the X/Y bus one at a time.
//  Every PE-side controller forwards ready: 1 on a tag mismatch, else the PE's ready.
//  Buses therefore return one AND-reduced gin_ready; a packet retires on gin_enable & gin_ready.
// PARAMETERS
//  ROW_ID_LEN  4   width of row (Y-bus) tag
//  COL_ID_LEN  4   width of column (X-bus) tag
//  VALUE_LEN   32  payload width
//  FIFO_DEPTH  4   queue entries; power of 2, >=2
//  CNT_LEN     16  width of sent/stall counters
// PORTS
//  clk          in   1            clock; all logic on rising edge
//  rst          in   1            synchronous reset, active-high
//  in_valid     in   1            upstream packet valid
//  in_ready     out  1            FIFO can accept (count < FIFO_DEPTH)
//  in_row_tag   in   ROW_ID_LEN   destination row id
//  in_col_tag   in   COL_ID_LEN   destination column id
//  in_value     in   VALUE_LEN    payload
//  gin_enable   out  1            packet on bus valid
//  gin_ready    in   1            AND-reduced ready from all tag-matched PEs
//  gin_row_tag  out  ROW_ID_LEN   bus row tag
//  gin_col_tag  out  COL_ID_LEN   bus column tag
//  gin_value    out  VALUE_LEN    bus payload
//  busy         out  1            FIFO non-empty or packet on bus
//  sent_count   out  CNT_LEN      retired packets since reset
//  stall_count  out  CNT_LEN      cycles with gin_enable & ~gin_ready (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - FIFO emptied; state IDLE.
//   - gin_enable=0, tag/value regs=0, sent_count=0, stall_count=0.
//   - in_ready=1 in the cycle after reset.
//  Reset mid-transfer drops queued and on-bus packets. No completion is reported for them.
//  Push: in_valid & in_ready at an edge writes FIFO[wr_ptr]. Pointers wrap modulo FIFO_DEPTH.
//   count is a separate log2(DEPTH)+1 bit counter.
//  Output stage is registered: gin_* are flops, never combinational from in_*.
//   Minimum latency: push at edge N -> gin_enable=1 after edge N+1.
//  FSM:
//   IDLE: gin_enable=0.
//    - FIFO non-empty -> load head into output regs, pop, go SEND.
//   SEND: gin_enable=1; tag/value held stable while gin_ready=0.
//    - gin_ready=1 & FIFO non-empty -> load next head, pop, stay SEND (back-to-back, no bubble).
//    - gin_ready=1 & FIFO empty -> go IDLE, gin_enable=0 next cycle.
//    - gin_ready=0 -> stay, sent_count/state unchanged.
//  Retire: sent_count += 1 on every edge with gin_enable & gin_ready. Wraps at 2^CNT_LEN.
//  Push and pop in the same cycle: count unchanged.
//   Full FIFO: in_ready=0 even if a pop occurs that cycle (no bypass).
//  Empty FIFO with in_valid in IDLE: the entry is written, then popped on the next edge.
//   There is no FIFO bypass.
//  gin_value driven 0 whenever gin_enable=0; tags keep their last value.
//  busy = (count != 0) | gin_enable.
// CONFIGURATION
//  GIN_SENDER_STALL_CNT_EN defined:
//   - stall_count increments each cycle gin_enable & ~gin_ready; saturates at all-ones.
//   - Cleared by rst.
//  Not defined: stall_count tied to 0; no counter flops are synthesised.
// TESTING
//  1. Single packet: push (row=2,col=5,val=0xA5A5_0001), gin_ready=1 ->
//     gin_enable high exactly 1 cycle, tags 2/5, sent_count=1, busy low after.
//  2. Back-to-back: push 4 packets on consecutive cycles, gin_ready=1 ->
//     4 consecutive gin_enable cycles, in order, no bubble; sent_count=4.
//  3. Backpressure: gin_ready=0 for 7 cycles with packet 0x11 on bus ->
//     tags/value stable, sent_count unchanged, stall_count=7 (macro on) / 0 (off).
//  4. Full FIFO: gin_ready=0, push 6 packets ->
//     in_ready drops after 4 queued plus 1 on bus; release ready -> all 5 emerge in order.
//  5. Simultaneous push/pop at count=2 -> count stays 2; pointer wrap after 9 packets keeps FIFO order.
//  6. rst asserted while gin_enable=1 and 3 queued ->
//     next cycle gin_enable=0, busy=0, sent_count=0, in_ready=1.

Source files
------------

// File: rtl/gin_multicast_sender_if.sv
// Handshake and bus bundle for the GIN multicast sender.
// The master modport is the sender side. The slave modport is the upstream buffer and the X/Y bus side.
interface gin_multicast_sender_if #(
  parameter int ROW_ID_LEN = 4,
  parameter int COL_ID_LEN = 4,
  parameter int VALUE_LEN  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ROW_ID_LEN-1:0] in_row_tag;
  logic [COL_ID_LEN-1:0] in_col_tag;
  logic [VALUE_LEN-1:0]  in_value;

  logic                  gin_enable;
  logic                  gin_ready;
  logic [ROW_ID_LEN-1:0] gin_row_tag;
  logic [COL_ID_LEN-1:0] gin_col_tag;
  logic [VALUE_LEN-1:0]  gin_value;

  modport master (
    input  in_valid, in_row_tag, in_col_tag, in_value, gin_ready,
    output in_ready, gin_enable, gin_row_tag, gin_col_tag, gin_value
  );

  modport slave (
    output in_valid, in_row_tag, in_col_tag, in_value, gin_ready,
    input  in_ready, gin_enable, gin_row_tag, gin_col_tag, gin_value
  );
endinterface

// File: rtl/gin_multicast_sender.sv
// GIN multicast bus source: a small FIFO feeding a registered X/Y bus output stage.
// Optional macro GIN_SENDER_STALL_CNT_EN enables the saturating stall-cycle counter.
module gin_multicast_sender #(
  parameter int ROW_ID_LEN = 4,
  parameter int COL_ID_LEN = 4,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_LEN    = 16
) (
  input  logic               clk,
  input  logic               rst,
  gin_multicast_sender_if.master bus,
  output logic               busy,
  output logic [CNT_LEN-1:0] sent_count,
  output logic [CNT_LEN-1:0] stall_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROW_ID_LEN-1:0] row;
    logic [COL_ID_LEN-1:0] col;
    logic [VALUE_LEN-1:0]  value;
  } pkt_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_next;

  pkt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ROW_ID_LEN-1:0] row_q;
  logic [COL_ID_LEN-1:0] col_q;
  logic [VALUE_LEN-1:0]  value_q;
  logic [CNT_LEN-1:0]    sent_q;

  logic fifo_nonempty;
  logic fifo_has_room;
  logic push;
  logic pop;
  logic retire;
  logic stall;
  logic drain;
  logic enable;
  pkt_t in_pkt;
  pkt_t head;

  // FIFO status and the upstream handshake. in_ready comes only from count,
  // so a full FIFO refuses input even in a cycle that pops.
  always_comb begin
    fifo_nonempty = (count != '0);
    fifo_has_room = (count < CNT_W'(FIFO_DEPTH));
    push          = bus.in_valid & fifo_has_room;
    in_pkt        = '{row: bus.in_row_tag, col: bus.in_col_tag, value: bus.in_value};
    head          = mem[rd_ptr];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_nonempty) state_next = SEND;
      SEND:    if (bus.gin_ready && !fifo_nonempty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    enable = 1'b0;
    pop    = 1'b0;
    retire = 1'b0;
    stall  = 1'b0;
    drain  = 1'b0;
    case (state)
      IDLE: begin
        pop = fifo_nonempty;
      end
      SEND: begin
        enable = 1'b1;
        retire = bus.gin_ready;
        stall  = ~bus.gin_ready;
        pop    = bus.gin_ready & fifo_nonempty;
        drain  = bus.gin_ready & ~fifo_nonempty;
      end
      default: ;
    endcase
  end

  // FIFO storage. The entries are not reset because count alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus output registers. The value is cleared on the way back to IDLE, so
  // gin_value stays a plain flop and still reads 0 while gin_enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      value_q <= '0;
    end else if (pop) begin
      row_q   <= head.row;
      col_q   <= head.col;
      value_q <= head.value;
    end else if (drain) begin
      value_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q <= '0;
    end else if (retire) begin
      sent_q <= sent_q + CNT_LEN'(1);
    end
  end

`ifdef GIN_SENDER_STALL_CNT_EN
  logic [CNT_LEN-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_LEN'(1);
    end
  end

  assign stall_count = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_count  = '0;
`endif

  assign bus.in_ready    = fifo_has_room;
  assign bus.gin_enable  = enable;
  assign bus.gin_row_tag = row_q;
  assign bus.gin_col_tag = col_q;
  assign bus.gin_value   = value_q;
  assign busy            = fifo_nonempty | enable;
  assign sent_count      = sent_q;

endmodule
